// File: rtl/passenger_fifo_pkg.sv
// Shared constants for the passenger/luggage sorting path: storage defaults and
// the ASCII codes the controller's type check relies on.
package passenger_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    localparam logic [7:0] END_SIGN    = 8'h24;
    localparam logic [7:0] LUGGAGE_MIN = 8'd49;
    localparam logic [7:0] LUGGAGE_MAX = 8'd57;

endpackage

// File: rtl/passenger_fifo_ptr.sv
// Wrap-bit FIFO pointer: low bits address memory, the MSB distinguishes full
// from empty when the low bits match.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/passenger_fifo.sv
// Synchronous character FIFO between the sorting controller and the output
// formatter; registered read data with one-cycle valid, sticky error flags.
module passenger_fifo
    import passenger_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = DEFAULT_DEPTH,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  is_fifo_empty,
    output logic                  is_fifo_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  overflow_q;
    logic                  underflow_q;

    // Status is derived purely from the pointer registers.
    assign is_fifo_empty = (wptr == rptr);
    assign is_fifo_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                           (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign count         = wptr - rptr;

    // A write into a full FIFO is only taken when a pop frees the head slot
    // on the same edge; an empty FIFO never forwards the incoming byte.
    assign rd_accept = !clear && rd_enable && !is_fifo_empty;
    assign wr_accept = !clear && wr_enable && (!is_fifo_full || rd_accept);

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (wr_accept),
        .ptr   (wptr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (rd_accept),
        .ptr   (rptr)
    );

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Stage p1: registered head entry and its valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_accept;
            if (rd_accept) begin
                data_p1 <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_enable && !wr_accept) begin
                overflow_q <= 1'b1;
            end
            if (rd_enable && is_fifo_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign data_out  = data_p1;
    assign out_valid = vld_p1;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/passenger_fifo.md
# passenger_fifo

Synchronous FIFO storage directly downstream of the FIFO controller in the passenger/luggage sorting path. It accepts the controller's `wr_enable`/`rd_enable` strobes and the passenger byte stream. It reports `is_fifo_empty` back to the controller, which uses it to end its POP phase. Read data is registered and qualified by `out_valid` for the output formatter.

## Interface
- `DATA_WIDTH`, 8: byte width of stored characters (ASCII).
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, log2(DEPTH): index width; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `clear`  in  1  synchronous flush; highest priority after reset.
- `wr_enable`  in  1  push `data_in` this cycle.
- `rd_enable`  in  1  pop head entry this cycle.
- `data_in`  in  DATA_WIDTH  character to store.
- `data_out`  out  DATA_WIDTH  registered head entry from the last accepted pop.
- `out_valid`  out  1  `data_out` holds data popped in the previous cycle.
- `is_fifo_empty`  out  1  count == 0.
- `is_fifo_full`  out  1  count == DEPTH.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers `wptr`/`rptr` are ADDR_WIDTH+1 bits. Low bits index memory; the MSB is a wrap bit. Both wrap from 2·DEPTH−1 to 0.
- Accepted write (`wr_accept`) = `wr_enable` && (!full || `rd_accept`). It stores `data_in` at mem[wptr] and increments wptr.
- Accepted read (`rd_accept`) = `rd_enable` && !empty. It registers mem[rptr] into `data_out`, increments rptr and sets `out_valid`=1 for one cycle.
- A read that is not accepted gives `out_valid`=0 and leaves `data_out` holding its last value.
- `count` changes by +1 on write only, −1 on read only, and 0 on both or neither.
- Empty and both strobes: the write is accepted. The read is rejected, `underflow` sets, and the head is not bypassed (no fall-through).
- Full and both strobes: both are accepted, `count` stays DEPTH and `overflow` does not set.
- Full and write only: the write is dropped, `overflow` sets, and memory and pointers are unchanged.
- `clear`=1: pointers, `count`, `out_valid`, `overflow` and `underflow` all go to 0. Any strobes in that cycle are ignored. Memory contents are not cleared.
- Stored characters are opaque: no type decoding happens here. The `$` end marker is never pushed by the controller.

## Timing
- Reset values, with `reset`=0 asynchronously: `data_out`=0, `out_valid`=0, `count`=0, `is_fifo_empty`=1, `is_fifo_full`=0, `overflow`=0, `underflow`=0, pointers=0.
- Reset mid-operation discards all contents immediately. The first write after release is the first entry read.
- Write-to-status latency is 1 cycle: `is_fifo_empty` falls on the edge that accepts the first write.
- Read latency is 1 cycle: `rd_enable` at edge N gives `data_out`/`out_valid` valid after edge N.
- Earliest readable entry: a write at edge N can be popped by `rd_enable` sampled at edge N+1.
- Status outputs are registered or derived only from registers; there are no combinational paths from inputs to outputs.
- Back-to-back reads stream one entry per cycle, with `out_valid` continuously high.

## Structure
- Shared package holds:
  - the DATA_WIDTH default;
  - ASCII constants: END_SIGN 8'h24, LUGGAGE_MIN 8'd49, LUGGAGE_MAX 8'd57;
  - the DEPTH default.
- The controller's type-check logic and this block both import that package.
- One sub-module, `fifo_ptr`: a wrap-bit pointer register with increment, clear and async active-low reset, instantiated twice.
- Memory is a plain register array with no reset.

## Test plan
- Reset, then push 'A','B','C' on 3 cycles, then 3 reads → `data_out` = 8'h41, 8'h42, 8'h43 on consecutive cycles; `out_valid` high 3 cycles; `is_fifo_empty`=1 after the last read.
- Push 16 bytes 0x60..0x6F, then a 17th byte 0x70 → `is_fifo_full`=1, `count`=16, `overflow`=1; reading 16 returns 0x60..0x6F and no 0x70.
- While full, assert `wr_enable`+`rd_enable` with `data_in`=0x50 for 20 cycles → `count` stays 16, no `overflow`; the read sequence is continuous across pointer wrap.
- While empty, assert `rd_enable`+`wr_enable` with 0x4B → `underflow`=1, `out_valid`=0; next cycle `count`=1, and a following read yields 0x4B.
- Fill with 5 entries, pulse `clear` with `wr_enable` high → `count`=0, `is_fifo_empty`=1, flags 0; the write is ignored.
- Drive `reset` low for half a cycle mid-stream with 7 entries stored → all outputs reach reset values without a clock edge; the next push/pop returns the new data.
